// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped, write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_INDEX_BITS = 4;

    function automatic int tag_bits_f(input int addr_width, input int index_bits);
        return addr_width - index_bits;
    endfunction

    function automatic int num_lines_f(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Flop-based line store: valid/tag/data per line, combinational lookup,
// one synchronous write port, valid bits cleared by synchronous reset.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int TAG_BITS   = DEFAULT_ADDR_WIDTH - DEFAULT_INDEX_BITS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int NUM_LINES = num_lines_f(INDEX_BITS);

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data are left unreset; the valid bit alone qualifies them.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data = data_q[rd_index];

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, write-allocate cache in front of main_memory.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // resp_valid is a one-cycle pulse completing the oldest accepted request.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_out,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_ctrl,
`ifdef CACHE_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    output state_t                dbg_state
);

    localparam int TAG_BITS = tag_bits_f(ADDR_WIDTH, INDEX_BITS);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    logic                  line_hit;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign mem_read_addr = addr_q;
    assign dbg_state     = state;

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lines (
        .clock    (clock),
        .reset    (reset),
        .rd_index (req_addr[INDEX_BITS-1:0]),
        .rd_tag   (req_addr[ADDR_WIDTH-1:INDEX_BITS]),
        .rd_hit   (line_hit),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // Line updates come from either a fill (FILL) or an accepted write (IDLE);
    // the two never coincide. Reset suppresses both so a dropped request leaves no trace.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = req_addr[INDEX_BITS-1:0];
        wr_tag   = req_addr[ADDR_WIDTH-1:INDEX_BITS];
        wr_data  = req_wdata;
        if (!reset) begin
            if (state == FILL) begin
                wr_en    = 1'b1;
                wr_index = addr_q[INDEX_BITS-1:0];
                wr_tag   = addr_q[ADDR_WIDTH-1:INDEX_BITS];
                wr_data  = mem_read_out;
            end else if (accept && req_write) begin
                wr_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write)     state_n = WRITE;
                    else if (!line_hit) state_n = FETCH;
                end
            end
            FETCH:   state_n = FILL;
            FILL:    state_n = IDLE;
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            mem_write_ctrl <= 1'b0;
        end else begin
            state          <= state_n;
            resp_valid     <= 1'b0;
            mem_write_ctrl <= 1'b0;
            if (accept) begin
                if (req_write) begin
                    mem_write_addr <= req_addr;
                    mem_write_data <= req_wdata;
                    mem_write_ctrl <= 1'b1;
                    resp_valid     <= 1'b1;
                    resp_data      <= req_wdata;
                end else if (line_hit) begin
                    resp_valid <= 1'b1;
                    resp_data  <= line_data;
                end else begin
                    addr_q <= req_addr;
                end
            end
            if (state == FILL) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_read_out;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !req_write) begin
            if (line_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: directed scenarios plus randomized traffic
// against a word-array memory model and a tag/valid view of the cache.
module tb_direct_mapped_cache;
    import cache_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int IB = 4;
    localparam int NL = 1 << IB;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_out;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ctrl;
    state_t        dbg_state;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    direct_mapped_cache #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INDEX_BITS (IB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_out   (mem_read_out),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_ctrl (mem_write_ctrl),
`ifdef CACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .dbg_state      (dbg_state)
    );

    // Backing store: registered read port, write on write_ctrl.
    logic [DW-1:0] mem_store [256];
    always @(posedge clock) begin
        mem_read_out <= mem_store[mem_read_addr];
        if (mem_write_ctrl) mem_store[mem_write_addr] <= mem_write_data;
    end

    // Reference model
    logic [DW-1:0]    ref_mem   [256];
    logic             ref_valid [NL];
    logic [AW-IB-1:0] ref_tag   [NL];
    int               exp_hits;
    int               exp_misses;

    // Scoreboard queues
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    logic [AW-1:0] wa_q  [$];
    logic [DW-1:0] wd_q  [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data 0x%0h expected no response", resp_data);
                end else begin
                    check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
                    check("resp_latency", 32'(cyc), 32'(due_q.pop_front()));
                end
            end
            if (mem_write_ctrl) begin
                if (wa_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_write: got addr 0x%0h expected no write", mem_write_addr);
                end else begin
                    check("mem_write_addr", 32'(mem_write_addr), 32'(wa_q.pop_front()));
                    check("mem_write_data", 32'(mem_write_data), 32'(wd_q.pop_front()));
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int waited);
        int               lat;
        logic [IB-1:0]    idx;
        logic [AW-IB-1:0] tag;
        idx       = a[IB-1:0];
        tag       = a[AW-1:IB];
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got ready 0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            ref_mem[a]     = d;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            exp_q.push_back(d);
            due_q.push_back(cyc + 1);
            wa_q.push_back(a);
            wd_q.push_back(d);
        end else begin
            if (ref_valid[idx] && ref_tag[idx] == tag) begin
                lat = 1;
                exp_hits++;
            end else begin
                lat = 3;
                exp_misses++;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tag;
            end
            exp_q.push_back(ref_mem[a]);
            due_q.push_back(cyc + lat);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wa_q.size() != 0) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("drain_resp_q", 32'(exp_q.size()), 32'd0);
        check("drain_write_q", 32'(wa_q.size()), 32'd0);
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
    endtask

    initial begin
        int            w;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            d            = DW'($urandom);
            mem_store[i] = d;
            ref_mem[i]   = d;
        end
        mem_store[5] = 16'hBEEF;
        ref_mem[5]   = 16'hBEEF;

        @(negedge clock);
        do_reset();
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_data", 32'(resp_data), 32'd0);
        check("reset_mem_write_ctrl", 32'(mem_write_ctrl), 32'd0);
        check("reset_mem_read_addr", 32'(mem_read_addr), 32'd0);
        check("reset_mem_write_addr", 32'(mem_write_addr), 32'd0);

        // 1: cold read miss
        issue(1'b0, 8'h05, 16'h0, w);
        check("t1_state_fetch", 32'(dbg_state), 32'(FETCH));
        check("t1_mem_read_addr", 32'(mem_read_addr), 32'h05);
        drain();

        // 2: read hit
        issue(1'b0, 8'h05, 16'h0, w);
        check("t2_no_fetch", 32'(dbg_state), 32'(IDLE));
        drain();
        check_stats();

        // 3: write to a conflicting address, read it back, then re-miss the evicted line
        issue(1'b1, 8'h15, 16'h1234, w);
        issue(1'b0, 8'h15, 16'h0, w);
        issue(1'b0, 8'h05, 16'h0, w);
        drain();

        // 4: back-to-back hits
        issue(1'b0, 8'h06, 16'h0, w);
        drain();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, (i % 2 == 0) ? 8'h05 : 8'h06, 16'h0, w);
            check("t4_ready_held", 32'(w), 32'd0);
        end
        drain();
        check_stats();

        // 5: reset while the miss is in FILL drops the request
        issue(1'b0, 8'h07, 16'h0, w);
        @(negedge clock);
        check("t5_state_fill", 32'(dbg_state), 32'(FILL));
        reset     = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        issue(1'b0, 8'h05, 16'h0, w);
        drain();
        check_stats();

        // 6: random traffic
        for (int n = 0; n < 2000; n++) begin
            wr = ($urandom_range(0, 2) == 0);
            a  = AW'($urandom_range(0, 255));
            d  = DW'($urandom);
            issue(wr, a, d, w);
            if ($urandom_range(0, 7) == 0) @(negedge clock);
        end
        drain();
        check_stats();
        for (int i = 0; i < 256; i++) check("mem_contents", 32'(mem_store[i]), 32'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
